// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard controller: MDU FSM state
// encoding, the hard-wired zero register and default MDU timing.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 4;
  localparam int         CNT_W_DEF   = 4;

  // True when an ID-stage source is actually read and names the EX destination.
  function automatic logic src_match(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage : hazard_pkg

// File: rtl/hazard_mdu_timer.sv
// MDU front-end hold sequencer: a start pulse in IDLE holds BUSY for exactly
// MDU_LAT cycles; starts seen while BUSY are ignored.
module hazard_mdu_timer
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MDU_LAT - 1);
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : hazard_mdu_timer

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, taken-branch squash and MDU
// front-end stall. Define HAZARD_PERF_EN to add saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       useRs_ID,
  input  logic       useRt_ID,
  input  logic       regWr_EX,
  input  logic       Wrback_EX,
  input  logic [4:0] dst_EX,
  input  logic       mduStart_EX,
  input  logic       brTaken_EX,
  output logic       stall_PC,
  output logic       stall_IFID,
  output logic       Flush_IFID,
  output logic       Flush_ID,
  output logic       mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_mdu_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic lu;
  logic busy;
  logic mdu_start;
  logic stall;

  assign lu = regWr_EX & Wrback_EX & (dst_EX != REG_ZERO) &
              (src_match(useRs_ID, rs_ID, dst_EX) |
               src_match(useRt_ID, rt_ID, dst_EX));

  // A taken branch squashes the MDU op too: it was issued on the wrong path.
  assign mdu_start = mduStart_EX & ~brTaken_EX;

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mdu_start),
    .busy_o  (busy)
  );

  // Outputs are gated by rst_n so the combinational lu/branch paths stay
  // quiet while the pipeline is held in reset.
  assign stall      = rst_n & (busy | (lu & ~brTaken_EX));
  assign stall_PC   = stall;
  assign stall_IFID = stall;
  assign Flush_ID   = rst_n & (busy | lu | brTaken_EX);
  assign Flush_IFID = rst_n & brTaken_EX & ~busy;
  assign mdu_busy   = rst_n & busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_mdu_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_mdu_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      if (lu && !brTaken_EX && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
      if (busy && (perf_mdu_q != '1))              perf_mdu_q <= perf_mdu_q + 32'd1;
      if (brTaken_EX && (perf_flush_q != '1))      perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_mdu_cnt   = perf_mdu_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; outputs compared as the vector
// {stall_PC, stall_IFID, Flush_IFID, Flush_ID, mdu_busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_ID, rt_ID, dst_EX;
  logic       useRs_ID, useRt_ID, regWr_EX, Wrback_EX, mduStart_EX, brTaken_EX;
  logic       stall_PC, stall_IFID, Flush_IFID, Flush_ID, mdu_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_mdu_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_LU   = 5'b11010;
  localparam logic [4:0] O_BUSY = 5'b11011;
  localparam logic [4:0] O_BR   = 5'b00110;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .useRs_ID    (useRs_ID),
    .useRt_ID    (useRt_ID),
    .regWr_EX    (regWr_EX),
    .Wrback_EX   (Wrback_EX),
    .dst_EX      (dst_EX),
    .mduStart_EX (mduStart_EX),
    .brTaken_EX  (brTaken_EX),
    .stall_PC    (stall_PC),
    .stall_IFID  (stall_IFID),
    .Flush_IFID  (Flush_IFID),
    .Flush_ID    (Flush_ID),
    .mdu_busy    (mdu_busy)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_mdu_cnt   (perf_mdu_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw, input logic wb,
                        input logic [4:0] dst, input logic mdu, input logic br);
    rs_ID = rs; rt_ID = rt; useRs_ID = urs; useRt_ID = urt;
    regWr_EX = rw; Wrback_EX = wb; dst_EX = dst; mduStart_EX = mdu; brTaken_EX = br;
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, stall_PC, stall_IFID, Flush_IFID, Flush_ID, mdu_busy};
  endfunction

  // One cycle: drive on the falling edge, check combinational outputs 1ns later.
  task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic rw, input logic wb,
                      input logic [4:0] dst, input logic mdu, input logic br,
                      input logic [4:0] exp);
    @(negedge clk);
    set_in(rs, rt, urs, urt, rw, wb, dst, mdu, br);
    #1 check(tag, outs(), {27'd0, exp});
  endtask

  task automatic idle(input string tag, input logic [4:0] exp);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset: outputs forced low even with lu, branch and MDU start driven.
    step("rst_quiet", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 check("rst_release", outs(), {27'd0, O_NONE});
    idle("post_rst_idle", O_NONE);

    // Load-use hazards and their non-hazard variants.
    step("lu_rs",      5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, O_LU);
    idle("lu_one_bubble", O_NONE);
    step("lu_reg0",    5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_NONE);
    step("lu_no_use",  5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, O_NONE);
    step("lu_rt",      5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, O_LU);
    step("lu_no_wr",   5'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, O_NONE);
    step("fwd_alu",    5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, O_NONE);
    step("lu_rt_miss", 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, O_NONE);

    // MDU hold: exactly 4 busy cycles; a second start mid-BUSY is ignored.
    step("mdu_start",  5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_NONE);
    idle("mdu_busy1", O_BUSY);
    step("mdu_busy2_restart", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_BUSY);
    idle("mdu_busy3", O_BUSY);
    idle("mdu_busy4", O_BUSY);
    idle("mdu_done",  O_NONE);
    idle("mdu_stays_idle", O_NONE);

    // Branch priority over load-use, and branch alone.
    step("br_over_lu", 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, O_BR);
    step("br_alone",   5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_BR);
    idle("br_after", O_NONE);

    // MDU start squashed by a simultaneous taken branch.
    step("mdu_br_same", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, O_BR);
    idle("mdu_br_no_busy", O_NONE);

    // MDU start with load-use: lu bubble then 4 busy cycles, no gap.
    step("mdu_lu_same", 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, O_LU);
    for (int i = 1; i <= 4; i++) idle($sformatf("mdu_lu_busy%0d", i), O_BUSY);
    idle("mdu_lu_done", O_NONE);

    // Branch during BUSY: Flush_IFID suppressed, stalls held, duration unchanged.
    step("br_busy_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_NONE);
    idle("br_busy1", O_BUSY);
    step("br_in_busy", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_BUSY);
    idle("br_busy3", O_BUSY);
    idle("br_busy4", O_BUSY);
    idle("br_busy_done", O_NONE);

    // Reset during the second BUSY cycle.
    step("rb_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_NONE);
    idle("rb_busy1", O_BUSY);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rb_rst_immediate", outs(), {27'd0, O_NONE});
    idle("rb_rst_hold", O_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rb_release", outs(), {27'd0, O_NONE});
    idle("rb_no_stall1", O_NONE);
    idle("rb_no_stall2", O_NONE);
    idle("rb_no_stall3", O_NONE);

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("perf_rst_lu", perf_lu_cnt, 32'd0);
    check("perf_rst_mdu", perf_mdu_cnt, 32'd0);
    check("perf_rst_flush", perf_flush_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step($sformatf("perf_lu%0d", i), 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, O_LU);
    step("perf_mdu_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_NONE);
    for (int i = 1; i <= 4; i++) idle($sformatf("perf_busy%0d", i), O_BUSY);
    idle("perf_gap", O_NONE);
    step("perf_br0", 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, O_BR);
    step("perf_br1", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, O_BR);
    idle("perf_tail", O_NONE);
    check("perf_lu_cnt", perf_lu_cnt, 32'd3);
    check("perf_mdu_cnt", perf_mdu_cnt, 32'd4);
    check("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_ctrl
